// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop iterated LSB-first
// over WIDTH bits, with a start/done handshake and registered sum/cout/ovf.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one operand bit per cycle through the full-adder cell
    // S_DONE | result registers just updated; done pulse, may accept a new start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             s_bit, c_next, load;

    assign s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign c_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) load = 1'b1;
            end
            S_RUN: begin
                carry_d  = c_next;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = {s_bit, res_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB at this point
                    sum_d   = {s_bit, res_sr_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    ovf_d   = carry_q ^ c_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) load = 1'b1;
                else         state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Subtraction runs as a + ~b + ~borrow through the same adder cell
        if (load) begin
            a_sr_d  = a_i;
            b_sr_d  = sub_i ? ~b_i : b_i;
            carry_d = sub_i ^ cin_i;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: cycle model + directed literals at WIDTH=8,
// exhaustive WIDTH=2 and random WIDTH=16 operations against an arithmetic golden model.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    // WIDTH=2 instance
    logic       start2 = 0, sub2 = 0, cin2 = 0;
    logic [1:0] a2 = 0, b2 = 0;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    // WIDTH=16 instance
    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
    );
    serial_addsub #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .sub_i(sub2), .a_i(a2), .b_i(b2),
        .cin_i(cin2), .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2), .ovf_o(ovf2)
    );
    serial_addsub #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .sub_i(sub16), .a_i(a16), .b_i(b16),
        .cin_i(cin16), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic definition of the result: unsigned value for sum/cout, signed range for ovf
    function automatic void golden(input int w, input bit sub, input longint a, input longint b,
                                   input bit cin, output longint s, output bit co, output bit ov);
        longint full, half, sa, sb, r, sr;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        if (!sub) begin
            r  = a + b + longint'(cin);
            co = (r >= full);
            sr = sa + sb + longint'(cin);
        end else begin
            r  = a - b - longint'(cin);
            co = (r >= 0);
            sr = sa - sb - longint'(cin);
        end
        s  = r & (full - 1);
        ov = (sr < -half) || (sr > half - 1);
    endfunction

    // Cycle-level expectation for the WIDTH=8 instance
    logic       m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
    logic [7:0] m_sum = 0, p_sum = 0;
    logic       p_cout = 0, p_ovf = 0;
    int         m_left = 0;
    logic       chk_en = 0;

    always @(posedge clk) begin : model8
        longint ts;
        bit tc, tv;
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_sum <= 0; m_cout <= 0; m_ovf <= 0; m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_sum  <= p_sum;
                m_cout <= p_cout;
                m_ovf  <= p_ovf;
            end
        end else begin
            m_done <= 0;
            if (start8) begin
                golden(8, sub8, longint'(a8), longint'(b8), cin8, ts, tc, tv);
                m_busy <= 1;
                m_left <= 8;
                p_sum  <= ts[7:0];
                p_cout <= tc;
                p_ovf  <= tv;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_busy", busy8, m_busy);
            chk("m8_done", done8, m_done);
            chk("m8_sum",  sum8,  m_sum);
            chk("m8_cout", cout8, m_cout);
            chk("m8_ovf",  ovf8,  m_ovf);
        end
    end

    task automatic op8(input string name, input bit sub, input logic [7:0] a, input logic [7:0] b,
                       input bit cin, input logic [7:0] es, input bit ec, input bit ev);
        int n;
        @(negedge clk);
        sub8 = sub; a8 = a; b8 = b; cin8 = cin; start8 = 1;
        n = 0;
        do begin
            @(negedge clk);
            start8 = 0;
            n++;
        end while (done8 !== 1'b1 && n < 40);
        chk({name, "_latency"}, n, 9);
        chk({name, "_sum"}, sum8, es);
        chk({name, "_cout"}, cout8, ec);
        chk({name, "_ovf"}, ovf8, ev);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        longint es;
        bit ec, ev;
        logic got2, got16;
        logic [1:0]  c_s2;
        logic [15:0] c_s16;
        logic c_c2, c_v2, c_c16, c_v16;

        // reset, with start asserted to show reset wins
        start8 = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum",  sum8,  0);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf",  ovf8,  0);
        start8 = 0;
        rst = 0;
        chk_en = 1;

        op8("add_5a_33", 0, 8'h5A, 8'h33, 0, 8'h8D, 0, 1);
        op8("add_ff_01", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        op8("add_00_cin", 0, 8'h00, 8'h00, 1, 8'h01, 0, 0);
        op8("sub_10_01", 1, 8'h10, 8'h01, 0, 8'h0F, 1, 0);
        op8("sub_00_01", 1, 8'h00, 8'h01, 0, 8'hFF, 0, 0);

        // start held through RUN with new operands, then still high in the DONE cycle
        @(negedge clk);
        sub8 = 0; a8 = 8'h5A; b8 = 8'h33; cin8 = 0; start8 = 1;
        @(negedge clk);
        chk("b2b_busy", busy8, 1);
        sub8 = 1; a8 = 8'h10; b8 = 8'h01; cin8 = 0;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("b2b_first_sum", sum8, 8'h8D);
        chk("b2b_first_cout", cout8, 0);
        chk("b2b_first_ovf", ovf8, 1);
        @(negedge clk);
        chk("b2b_busy_next", busy8, 1);
        start8 = 0;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("b2b_second_sum", sum8, 8'h0F);
        chk("b2b_second_cout", cout8, 1);
        chk("b2b_second_ovf", ovf8, 0);

        // reset in the middle of an operation
        @(negedge clk);
        sub8 = 0; a8 = 8'h11; b8 = 8'h22; cin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_sum",  sum8,  0);
        chk("midrst_cout", cout8, 0);
        rst = 0;
        k = 0;
        repeat (12) begin @(negedge clk); if (done8 === 1'b1) k++; end
        chk("midrst_no_done", k, 0);

        op8("sub_80_01", 1, 8'h80, 8'h01, 0, 8'h7F, 1, 1);

        // WIDTH=2 exhaustive (cycled) alongside WIDTH=16 random
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            k = i % 64;
            cin2 = k[0]; b2 = k[2:1]; a2 = k[4:3]; sub2 = k[5];
            if (i == 0) begin
                a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 0; cin16 = 0;
            end else if (i == 1) begin
                a16 = 16'h8000; b16 = 16'h0000; sub16 = 1; cin16 = 1;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                sub16 = 1'($urandom_range(0, 1)); cin16 = 1'($urandom_range(0, 1));
            end
            start2 = 1; start16 = 1;
            got2 = 0; got16 = 0; n = 0;
            c_s2 = 0; c_c2 = 0; c_v2 = 0; c_s16 = 0; c_c16 = 0; c_v16 = 0;
            while (!(got2 && got16) && n < 40) begin
                @(negedge clk);
                start2 = 0; start16 = 0;
                n++;
                if (done2 === 1'b1 && !got2) begin
                    got2 = 1; c_s2 = sum2; c_c2 = cout2; c_v2 = ovf2;
                end
                if (done16 === 1'b1 && !got16) begin
                    got16 = 1; c_s16 = sum16; c_c16 = cout16; c_v16 = ovf16;
                end
            end
            chk("w2_done", got2, 1);
            chk("w16_done", got16, 1);
            golden(2, sub2, longint'(a2), longint'(b2), cin2, es, ec, ev);
            chk("w2_sum", c_s2, es);
            chk("w2_cout", c_c2, ec);
            chk("w2_ovf", c_v2, ev);
            golden(16, sub16, longint'(a16), longint'(b16), cin16, es, ec, ev);
            chk("w16_sum", c_s16, es);
            chk("w16_cout", c_c16, ec);
            chk("w16_ovf", c_v16, ev);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
